// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - datapath-facing signal bundle of the control sequencer
// master = sequencer (drives strobes), slave = datapath (drives IR/CON_FF/Stop).
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Stop;
  logic [4:0]  opcode;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout;
  logic        Cout, CONin, Inportout, Outportin, Read, Write;
  logic        Run;

  modport master (
    input  IR, CON_FF, Stop,
    output opcode, Gra, Grb, Grc, Rin, Rout, BAout,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
    output Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
    output Cout, CONin, Inportout, Outportin, Read, Write, Run
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  opcode, Gra, Grb, Grc, Rin, Rout, BAout,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
    input  Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
    input  Cout, CONin, Inportout, Outportin, Read, Write, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore T0..T7 control unit for the 32-bit datapath
// Optional macro MUL_DIV_EN decodes mul/div; otherwise those opcodes behave as nop.
module control_sequencer #(
  parameter logic [4:0]  ADD_OP = 5'b00011,
  parameter int unsigned STEP_W = 4
) (
  input logic           Clock,
  input logic           clear,
  control_sequencer_if.master bus
);
  typedef enum logic [STEP_W-1:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LD, C_LDI, C_ST, C_BRX, C_JR, C_JAL,
    C_IN, C_OUT, C_MFHI, C_MFLO, C_MULDIV, C_HALT, C_NOP
  } cls_t;

  state_t     state_q, state_d;
  logic [4:0] op_q;
  logic       con_q;
  logic [4:0] op_now;
  cls_t       cls;

  function automatic cls_t classify(input logic [4:0] op);
    cls_t c;
    case (op) inside
      5'b00000:           c = C_LD;
      5'b00001:           c = C_LDI;
      5'b00010:           c = C_ST;
      [5'b00011:5'b01010]: c = C_ALU;
      [5'b01011:5'b01101]: c = C_IMM;
`ifdef MUL_DIV_EN
      5'b01110, 5'b01111: c = C_MULDIV;
`else
      5'b01110, 5'b01111: c = C_NOP;
`endif
      5'b10010:           c = C_BRX;
      5'b10011:           c = C_JR;
      5'b10100:           c = C_JAL;
      5'b10101:           c = C_IN;
      5'b10110:           c = C_OUT;
      5'b10111:           c = C_MFHI;
      5'b11000:           c = C_MFLO;
      5'b11010:           c = C_HALT;
      default:            c = C_NOP;
    endcase
    return c;
  endfunction

  function automatic state_t last_step(input cls_t c);
    state_t s;
    case (c)
      C_ALU, C_IMM, C_LDI: s = S_T5;
      C_LD, C_ST:          s = S_T7;
      C_BRX, C_MULDIV:     s = S_T6;
      C_JAL:               s = S_T4;
      default:             s = S_T3;
    endcase
    return s;
  endfunction

  // IR is freshly loaded at the end of T2, so T3 decodes it live and later steps use the copy.
  assign op_now = (state_q inside {S_T4, S_T5, S_T6, S_T7}) ? op_q : bus.IR[31:27];
  assign cls    = classify(op_now);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_q == S_T3 && cls == C_HALT)  state_d = S_HALT;
        else if (state_q == last_step(cls))    state_d = bus.Stop ? S_HALT : S_T0;
        else                                   state_d = state_t'(state_q + 1'b1);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_RESET;
      op_q    <= 5'b0;
      con_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T3) op_q  <= bus.IR[31:27];
      if (state_q == S_T5) con_q <= bus.CON_FF;
    end
  end

  always_comb begin
    {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout} = '0;
    {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin} = '0;
    {bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.HIout, bus.LOin, bus.LOout} = '0;
    {bus.Cout, bus.CONin, bus.Inportout, bus.Outportin, bus.Read, bus.Write} = '0;
    bus.Run    = (state_q != S_HALT);
    bus.opcode = (state_q == S_RESET) ? 5'b0 : op_now;
    case (state_q)
      S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
      S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (cls)
          C_ALU, C_IMM, C_MULDIV: begin
            case (state_q)
              S_T3: begin
                bus.Rout = 1'b1; bus.Yin = 1'b1;
                if (cls == C_MULDIV) bus.Gra = 1'b1; else bus.Grb = 1'b1;
              end
              S_T4: begin
                bus.Zin = 1'b1;
                if (cls == C_IMM)         bus.Cout = 1'b1;
                else if (cls == C_ALU)    begin bus.Grc = 1'b1; bus.Rout = 1'b1; end
                else                      begin bus.Grb = 1'b1; bus.Rout = 1'b1; end
              end
              S_T5: begin
                bus.Zlowout = 1'b1;
                if (cls == C_MULDIV) bus.LOin = 1'b1; else begin bus.Gra = 1'b1; bus.Rin = 1'b1; end
              end
              S_T6: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
              default: ;
            endcase
          end
          C_LD, C_LDI, C_ST: begin
            case (state_q)
              S_T3: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
              S_T4: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = ADD_OP; end
              S_T5: begin
                bus.Zlowout = 1'b1;
                if (cls == C_LDI) begin bus.Gra = 1'b1; bus.Rin = 1'b1; end else bus.MARin = 1'b1;
              end
              S_T6: begin
                bus.MDRin = 1'b1;
                if (cls == C_ST) begin bus.Gra = 1'b1; bus.Rout = 1'b1; end else bus.Read = 1'b1;
              end
              S_T7: begin
                if (cls == C_ST) bus.Write = 1'b1;
                else begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              end
              default: ;
            endcase
          end
          C_BRX: begin
            case (state_q)
              S_T3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
              S_T4: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
              S_T5: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = ADD_OP; end
              S_T6: begin bus.Zlowout = 1'b1; bus.PCin = con_q; end
              default: ;
            endcase
          end
          C_JR:   if (state_q == S_T3) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          C_JAL: begin
            if (state_q == S_T3) begin bus.PCout = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1; end
            if (state_q == S_T4) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          end
          C_IN:   if (state_q == S_T3) begin bus.Inportout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_OUT:  if (state_q == S_T3) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Outportin = 1'b1; end
          C_MFHI: if (state_q == S_T3) begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_MFLO: if (state_q == S_T3) begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
// Table of per-instruction step vectors plus hand-written reset/stop/halt sequences.
module tb_control_sequencer;
  localparam logic [27:0] RUN = 28'd1 << 0,  WRITE = 28'd1 << 1,  READ = 28'd1 << 2;
  localparam logic [27:0] OUTPORTIN = 28'd1 << 3, INPORTOUT = 28'd1 << 4, CONIN = 28'd1 << 5;
  localparam logic [27:0] COUT = 28'd1 << 6, LOOUT = 28'd1 << 7, LOIN = 28'd1 << 8;
  localparam logic [27:0] HIOUT = 28'd1 << 9, HIIN = 28'd1 << 10, ZHIGHOUT = 28'd1 << 11;
  localparam logic [27:0] ZLOWOUT = 28'd1 << 12, ZIN = 28'd1 << 13, YIN = 28'd1 << 14;
  localparam logic [27:0] IRIN = 28'd1 << 15, MDROUT = 28'd1 << 16, MDRIN = 28'd1 << 17;
  localparam logic [27:0] MARIN = 28'd1 << 18, INCPC = 28'd1 << 19, PCIN = 28'd1 << 20;
  localparam logic [27:0] PCOUT = 28'd1 << 21, BAOUT = 28'd1 << 22, ROUT = 28'd1 << 23;
  localparam logic [27:0] RIN = 28'd1 << 24, GRC = 28'd1 << 25, GRB = 28'd1 << 26, GRA = 28'd1 << 27;
  localparam logic [27:0] F0 = RUN | PCOUT | MARIN | INCPC | ZIN;
  localparam logic [27:0] F1 = RUN | ZLOWOUT | PCIN | READ | MDRIN;
  localparam logic [27:0] F2 = RUN | MDROUT | IRIN;
  localparam logic [4:0]  ADD_OP = 5'b00011;

  typedef struct {
    string            name;
    logic [31:0]      ir;
    logic             con;
    int               n;
    int               aidx;
    logic [4:0][27:0] e;
  } vec_t;

  typedef struct {
    string       name;
    logic [27:0] e;
    logic [4:0]  op;
    bit          chk_op;
  } sb_t;

  logic clk = 1'b0;
  logic clear;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  sb_t  sbq[$];

  control_sequencer_if bus();
  control_sequencer dut (.Clock(clk), .clear(clear), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [27:0] dut_vec();
    return {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.PCout, bus.PCin,
            bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zin,
            bus.Zlowout, bus.Zhighout, bus.HIin, bus.HIout, bus.LOin, bus.LOout, bus.Cout,
            bus.CONin, bus.Inportout, bus.Outportin, bus.Read, bus.Write, bus.Run};
  endfunction

  function automatic vec_t mk(string name, logic [31:0] ir, logic con, int n, int aidx,
                              logic [27:0] e3, logic [27:0] e4, logic [27:0] e5,
                              logic [27:0] e6, logic [27:0] e7);
    vec_t v;
    v.name = name; v.ir = ir; v.con = con; v.n = n; v.aidx = aidx;
    v.e[0] = e3; v.e[1] = e4; v.e[2] = e5; v.e[3] = e6; v.e[4] = e7;
    return v;
  endfunction

  task automatic check_now(string name, logic [27:0] e, logic [4:0] op, bit chk_op);
    logic [27:0] a;
    a = dut_vec();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s strobes: got %h expected %h", name, a, e);
    end
    if (chk_op) begin
      checks++;
      if (bus.opcode !== op) begin
        failures++;
        $display("FAIL %s opcode: got %b expected %b", name, bus.opcode, op);
      end
    end
    checks++;
    if ((a & (READ | WRITE)) == (READ | WRITE) ||
        ((a & (RIN | ROUT | BAOUT)) != 0 && $countones(a & (GRA | GRB | GRC)) != 1)) begin
      failures++;
      $display("FAIL %s invariant: strobes %h break Read/Write or Gr-select rule", name, a);
    end
  endtask

  task automatic sb_push(string name, logic [27:0] e, logic [4:0] op, bit chk_op);
    sb_t s;
    s.name = name; s.e = e; s.op = op; s.chk_op = chk_op;
    sbq.push_back(s);
  endtask

  task automatic sb_pop_check();
    sb_t s;
    if (sbq.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      s = sbq.pop_front();
      check_now(s.name, s.e, s.op, s.chk_op);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] irop;
    clear = 1'b0; bus.IR = 32'h0; bus.CON_FF = 1'b0; bus.Stop = 1'b0;

    tbl.push_back(mk("add",  32'h18A20000, 1'b0, 3, 0, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZIN, RUN|ZLOWOUT|GRA|RIN, 0, 0));
    tbl.push_back(mk("sub",  32'h20000000, 1'b0, 3, 0, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZIN, RUN|ZLOWOUT|GRA|RIN, 0, 0));
    tbl.push_back(mk("rol",  32'h50000000, 1'b0, 3, 0, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZIN, RUN|ZLOWOUT|GRA|RIN, 0, 0));
    tbl.push_back(mk("ori",  32'h6A880064, 1'b0, 3, 0, RUN|GRB|ROUT|YIN, RUN|COUT|ZIN, RUN|ZLOWOUT|GRA|RIN, 0, 0));
    tbl.push_back(mk("addi", 32'h58000000, 1'b0, 3, 0, RUN|GRB|ROUT|YIN, RUN|COUT|ZIN, RUN|ZLOWOUT|GRA|RIN, 0, 0));
    tbl.push_back(mk("ld",   32'h00800010, 1'b0, 5, 4, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN, RUN|ZLOWOUT|MARIN,
                     RUN|READ|MDRIN, RUN|MDROUT|GRA|RIN));
    tbl.push_back(mk("ldi",  32'h08800005, 1'b0, 3, 4, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN, RUN|ZLOWOUT|GRA|RIN, 0, 0));
    tbl.push_back(mk("st",   32'h12000054, 1'b0, 5, 4, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN, RUN|ZLOWOUT|MARIN,
                     RUN|GRA|ROUT|MDRIN, RUN|WRITE));
    tbl.push_back(mk("brx1", 32'h90000003, 1'b1, 4, 5, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN, RUN|COUT|ZIN, RUN|ZLOWOUT|PCIN, 0));
    tbl.push_back(mk("brx0", 32'h90000003, 1'b0, 4, 5, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN, RUN|COUT|ZIN, RUN|ZLOWOUT, 0));
    tbl.push_back(mk("jr",   32'h98000000, 1'b0, 1, 0, RUN|GRA|ROUT|PCIN, 0, 0, 0, 0));
    tbl.push_back(mk("jal",  32'hA0000000, 1'b0, 2, 0, RUN|PCOUT|GRB|RIN, RUN|GRA|ROUT|PCIN, 0, 0, 0));
    tbl.push_back(mk("in",   32'hA8000000, 1'b0, 1, 0, RUN|INPORTOUT|GRA|RIN, 0, 0, 0, 0));
    tbl.push_back(mk("out",  32'hB0000000, 1'b0, 1, 0, RUN|GRA|ROUT|OUTPORTIN, 0, 0, 0, 0));
    tbl.push_back(mk("mfhi", 32'hB8000000, 1'b0, 1, 0, RUN|HIOUT|GRA|RIN, 0, 0, 0, 0));
    tbl.push_back(mk("mflo", 32'hC0000000, 1'b0, 1, 0, RUN|LOOUT|GRA|RIN, 0, 0, 0, 0));
    tbl.push_back(mk("nop",  32'hC8000000, 1'b0, 1, 0, RUN, 0, 0, 0, 0));
    tbl.push_back(mk("undef", 32'hF8000000, 1'b0, 1, 0, RUN, 0, 0, 0, 0));
`ifdef MUL_DIV_EN
    tbl.push_back(mk("mul",  32'h70000000, 1'b0, 4, 0, RUN|GRA|ROUT|YIN, RUN|GRB|ROUT|ZIN, RUN|ZLOWOUT|LOIN,
                     RUN|ZHIGHOUT|HIIN, 0));
`else
    tbl.push_back(mk("mul",  32'h70000000, 1'b0, 1, 0, RUN, 0, 0, 0, 0));
`endif

    repeat (2) @(negedge clk);
    check_now("reset_hold", RUN, 5'd0, 1'b1);
    clear = 1'b1; #1;
    check_now("reset_released", RUN, 5'd0, 1'b1);
    @(negedge clk);
    check_now("t0_after_reset", F0, 5'd0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.IR = tbl[i].ir; bus.CON_FF = tbl[i].con; #1;
      irop = tbl[i].ir[31:27];
      sb_push({tbl[i].name, ".T0"}, F0, irop, 1'b0);
      sb_push({tbl[i].name, ".T1"}, F1, irop, 1'b1);
      sb_push({tbl[i].name, ".T2"}, F2, irop, 1'b1);
      for (int k = 0; k < tbl[i].n; k++)
        sb_push($sformatf("%s.T%0d", tbl[i].name, k + 3), tbl[i].e[k],
                (tbl[i].aidx == k + 3) ? ADD_OP : irop, 1'b1);
      for (int j = 0; j < tbl[i].n + 3; j++) begin
        if (j != 0) @(negedge clk);
        sb_pop_check();
      end
      @(negedge clk);
    end
    check_now("t0_after_table", F0, 5'd0, 1'b0);

    // Stop raised in T4 of an add: instruction completes, then HALT; Stop alone never resumes.
    bus.IR = 32'h18A20000; bus.CON_FF = 1'b0; #1;
    repeat (4) @(negedge clk);
    check_now("stop_add.T4", RUN|GRC|ROUT|ZIN, 5'b00011, 1'b1);
    bus.Stop = 1'b1;
    @(negedge clk);
    check_now("stop_add.T5", RUN|ZLOWOUT|GRA|RIN, 5'b00011, 1'b1);
    @(negedge clk);
    check_now("stop_add.halt", 28'd0, 5'd0, 1'b0);
    bus.Stop = 1'b0;
    repeat (2) @(negedge clk);
    check_now("stop_add.halt_held", 28'd0, 5'd0, 1'b0);
    clear = 1'b0; #1;
    check_now("halt_clear.reset", RUN, 5'd0, 1'b1);
    @(negedge clk); clear = 1'b1;
    @(negedge clk);
    check_now("halt_clear.T0", F0, 5'd0, 1'b0);

    // halt opcode together with Stop: single path into HALT after T3.
    bus.IR = 32'hD0000000; bus.Stop = 1'b1; #1;
    @(negedge clk);
    check_now("halt_op.T1", F1, 5'b11010, 1'b1);
    repeat (2) @(negedge clk);
    check_now("halt_op.T3", RUN, 5'b11010, 1'b1);
    @(negedge clk);
    check_now("halt_op.halt", 28'd0, 5'd0, 1'b0);
    bus.Stop = 1'b0;
    clear = 1'b0; @(negedge clk); clear = 1'b1;
    @(negedge clk);
    check_now("halt_op.T0", F0, 5'd0, 1'b0);

    // Reset during st T6 must abandon the store before its Write step.
    bus.IR = 32'h12000054; #1;
    repeat (6) @(negedge clk);
    check_now("st_abort.T6", RUN|GRA|ROUT|MDRIN, 5'b00010, 1'b1);
    clear = 1'b0; #1;
    check_now("st_abort.reset", RUN, 5'd0, 1'b1);
    @(negedge clk);
    check_now("st_abort.no_write", RUN, 5'd0, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    check_now("st_abort.T0", F0, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit for the 32-bit datapath.
- Walks a T0..T7 step sequence per instruction and decodes IR[31:27] into the full datapath control vector. Within each step it is the same vector the datapath bench drives by hand.
- Sits beside the datapath: consumes IR, CON_FF, Stop and Reset_sys; produces every select/enable/Run strobe.

Parameters:
- ADD_OP, 5'b00011, ALU opcode forced during address/branch-target computation.
- STEP_W, 4, width of internal state register.

Ports:
- Clock  input  1  system clock, all state updates on rising edge.
- clear  input  1  asynchronous, active-low reset.
- IR  input  32  instruction register contents; opcode = IR[31:27].
- CON_FF  input  1  branch-condition flip-flop from datapath.
- Stop  input  1  halt request, level-sensitive.
- opcode  output  5  ALU operation select.
- Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-file select/enable.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout, CONin, Inportout, Outportin, Read, Write  output  1 each  datapath strobes.
- Run  output  1  high while executing, low in HALT.

Behaviour:
- States:
  - RESET, T0, T1, T2: fetch.
  - T3..T7: execute.
  - HALT.
- One state per Clock edge. All outputs are a pure function of state plus latched IR/CON_FF (Moore); no output glitches across edges.
- clear low: state=RESET immediately; every output 0 except Run=1.
- RESET→T0 on the first edge after clear deasserts. Reset mid-instruction abandons it; no Write/Rin pulse may complete.
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
- The opcode decision is taken in T3 from IR as loaded in T2.
- opcode output = IR[31:27] in all states except address/target steps, where opcode=ADD_OP.
- Execute steps by opcode class. After the last listed step, go to T0 (or to HALT if Stop=1 at that edge).
  - ALU R-type (add 00011, sub 00100, and 00101, or 00110, shr/shl/ror/rol 00111-01010):
    - T3: Grb Rout Yin.
    - T4: Grc Rout Zin.
    - T5: Zlowout Gra Rin.
  - Immediate (addi 01011, andi 01100, ori 01101):
    - T3: Grb Rout Yin.
    - T4: Cout Zin.
    - T5: Zlowout Gra Rin.
  - ld 00000:
    - T3: Grb BAout Yin.
    - T4: Cout Zin (ADD_OP).
    - T5: Zlowout MARin.
    - T6: Read MDRin.
    - T7: MDRout Gra Rin.
  - ldi 00001: T3-T4 as ld; T5: Zlowout Gra Rin.
  - st 00010:
    - T3-T5 as ld.
    - T6: Gra Rout MDRin (Read=0).
    - T7: Write.
  - brx 10010:
    - T3: Gra Rout CONin.
    - T4: PCout Yin.
    - T5: Cout Zin (ADD_OP).
    - T6: Zlowout, with PCin only if CON_FF=1 sampled at end of T5.
  - jr 10011: T3: Gra Rout PCin.
  - jal 10100:
    - T3: PCout Grb Rin (link).
    - T4: Gra Rout PCin.
  - in 10101: T3: Inportout Gra Rin.
  - out 10110: T3: Gra Rout Outportin.
  - mfhi 10111: T3: HIout Gra Rin.
  - mflo 11000: T3: LOout Gra Rin.
  - nop 11001: T3 with no strobes.
  - halt 11010: T3→HALT.
  - Any unlisted opcode behaves as nop.
- HALT:
  - All strobes 0, Run=0. Held until clear asserts.
  - Stop alone never resumes.
- Stop is checked only at instruction boundaries (the edge leaving the last step); an in-flight instruction always completes.
- Simultaneous Stop and halt opcode → HALT (single path).
- Read and Write are never high in the same state; exactly one of Gra/Grb/Grc is high whenever Rin, Rout or BAout is high.

Optional Feature:
- Macro MUL_DIV_EN.
- Defined: mul 01110 and div 01111 decode as:
  - T3: Gra Rout Yin.
  - T4: Grb Rout Zin.
  - T5: Zlowout LOin.
  - T6: Zhighout HIin.
- Undefined: 01110/01111 decode as nop (T3 only, no strobes).

Test Plan:
- Hold clear low 2 cycles, release → all strobes 0 and Run=1 during RESET; T0 asserts PCout=MARin=IncPC=Zin=1 on the next cycle.
- IR=32'h6A880064 (ori, opcode 01101) → T3 Grb+Rout+Yin, T4 Cout+Zin with opcode=01101, T5 Zlowout+Gra+Rin; T0 follows in cycle 6.
- IR=32'h12000054 (st, 00010) → T4 opcode=00011, T6 Gra+Rout+MDRin with Read=0, T7 Write=1 for exactly one cycle.
- brx with CON_FF=1 then CON_FF=0 → PCin=1 in T6 only in the first case; Zlowout=1 in T6 in both.
- Stop raised during T4 of an add → add completes through T5, next state HALT, Run=0; Stop dropped → stays HALT; clear low → RESET.
- With MUL_DIV_EN, IR opcode 01110 → LOin in T5, HIin in T6; without the macro, same IR → T3 idle then T0.
